// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - recovers hex digits from a scanned active-low 7-segment bus
module seven_segment_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   dp,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    pattern_err,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES);
   // The counter value seen on the cycle whose stable sample is the last one required;
   // the counter would reach SETTLE_CYCLES-1 on that edge, so capture happens there.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_CAPTURED = 2'd2
   } state_t;

   // synchronizer and previous-sample registers (reset to all-ones = blank, no anode)
   logic [7:0]            seg_meta_q, seg_meta_d;
   logic [7:0]            seg_sync_q, seg_sync_d;
   logic [7:0]            seg_prev_q, seg_prev_d;
   logic [NUM_DIGITS-1:0] an_meta_q, an_meta_d;
   logic [NUM_DIGITS-1:0] an_sync_q, an_sync_d;
   logic [NUM_DIGITS-1:0] an_prev_q, an_prev_d;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic                    pattern_err_q, pattern_err_d;
   logic                    frame_done_q, frame_done_d;

   logic [NUM_DIGITS-1:0] an_act;
   logic                  an_onehot;
   logic                  in_stable;
   logic                  capture;
   logic [4:0]            glyph;

   // Returns {valid, value} for an active-low glyph on segments g..a.
   function automatic logic [4:0] glyph_decode(input logic [6:0] g);
      logic [4:0] r;
      case (g)
         7'h40:   r = 5'h10;
         7'h79:   r = 5'h11;
         7'h24:   r = 5'h12;
         7'h30:   r = 5'h13;
         7'h19:   r = 5'h14;
         7'h12:   r = 5'h15;
         7'h02:   r = 5'h16;
         7'h78:   r = 5'h17;
         7'h00:   r = 5'h18;
         7'h10:   r = 5'h19;
         7'h08:   r = 5'h1A;
         7'h03:   r = 5'h1B;
         7'h46:   r = 5'h1C;
         7'h21:   r = 5'h1D;
         7'h06:   r = 5'h1E;
         7'h0E:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // two-stage synchronizer plus one-cycle history for the stability compare
   always_comb begin
      seg_meta_d = seg_n;
      seg_sync_d = seg_meta_q;
      seg_prev_d = seg_sync_q;
      an_meta_d  = an_n;
      an_sync_d  = an_meta_q;
      an_prev_d  = an_sync_q;
   end

   // synchronizer register bank
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_meta_q <= '1;
         seg_sync_q <= '1;
         seg_prev_q <= '1;
         an_meta_q  <= '1;
         an_sync_q  <= '1;
         an_prev_q  <= '1;
      end else begin
         seg_meta_q <= seg_meta_d;
         seg_sync_q <= seg_sync_d;
         seg_prev_q <= seg_prev_d;
         an_meta_q  <= an_meta_d;
         an_sync_q  <= an_sync_d;
         an_prev_q  <= an_prev_d;
      end
   end

   // bus qualification: which digit is driven, and whether the bus held still
   always_comb begin
      an_act    = ~an_sync_q;
      an_onehot = $onehot(an_act);
      in_stable = (an_sync_q == an_prev_q) && (seg_sync_q == seg_prev_q);
      glyph     = glyph_decode(seg_sync_q[6:0]);
   end

   // FSM state register with settle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next-state: any change of the sampled bus restarts the settle window
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (an_onehot) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (!an_onehot) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (!in_stable) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_CAPTURED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_CAPTURED: begin
            if (!in_stable) begin
               state_d = an_onehot ? ST_SETTLE : ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM output: capture strobe on the edge the last required stable sample is seen
   always_comb begin
      capture = (state_q == ST_SETTLE) && an_onehot && in_stable && (cnt_q == CNT_LAST);
   end

   // capture datapath: update the selected digit, flag bad glyphs, track frame coverage
   always_comb begin
      digits_d      = digits_q;
      dp_d          = dp_q;
      digit_valid_d = digit_valid_q;
      seen_d        = seen_q;
      pattern_err_d = 1'b0;
      frame_done_d  = 1'b0;
      if (capture) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_act[i]) begin
               dp_d[i] = ~seg_sync_q[7];
               if (glyph[4]) begin
                  digits_d[4*i +: 4] = glyph[3:0];
                  digit_valid_d[i]   = 1'b1;
               end else begin
                  digit_valid_d[i] = 1'b0;
               end
            end
         end
         pattern_err_d = ~glyph[4];
         seen_d        = seen_q | an_act;
         if (&seen_d) begin
            frame_done_d = 1'b1;
            seen_d       = '0;
         end
      end
   end

   // output and coverage registers
   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q      <= '0;
         dp_q          <= '0;
         digit_valid_q <= '0;
         seen_q        <= '0;
         pattern_err_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         digits_q      <= digits_d;
         dp_q          <= dp_d;
         digit_valid_q <= digit_valid_d;
         seen_q        <= seen_d;
         pattern_err_q <= pattern_err_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign digits      = digits_q;
   assign dp          = dp_q;
   assign digit_valid = digit_valid_q;
   assign pattern_err = pattern_err_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb/tb_seven_segment_scan_decoder.sv - self-checking bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    seg_n;
   logic [ND-1:0] an_n;
   logic [4*ND-1:0] digits;
   logic [ND-1:0] dp;
   logic [ND-1:0] digit_valid;
   logic          pattern_err;
   logic          frame_done;

   int n_cmp = 0;
   int n_bad = 0;
   int frame_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   seven_segment_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .digits      (digits),
      .dp          (dp),
      .digit_valid (digit_valid),
      .pattern_err (pattern_err),
      .frame_done  (frame_done)
   );

   // reference glyphs, index = hex value
   logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   function automatic int glyph_value(input logic [6:0] g);
      for (int k = 0; k < 16; k++) begin
         if (glyph_tab[k] == g) return k;
      end
      return -1;
   endfunction

   // reference model: a bus value is captured once it has been seen SC times in a row
   // after the two-cycle input delay, provided exactly one anode is driven
   logic [11:0]     m_new = 12'hFFF, m_old = 12'hFFF, m_last = 12'hFFF, m_cur;
   int              m_run = 0;
   int              m_idx, m_val;
   logic [4*ND-1:0] m_digits = '0;
   logic [ND-1:0]   m_dp = '0, m_valid = '0, m_seen = '0;
   logic            m_err = 1'b0, m_frame = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_new = 12'hFFF; m_old = 12'hFFF; m_last = 12'hFFF; m_run = 0;
         m_digits = '0; m_dp = '0; m_valid = '0; m_seen = '0;
         m_err = 1'b0; m_frame = 1'b0;
      end else begin
         m_cur = m_old;
         m_old = m_new;
         m_new = {an_n, seg_n};
         m_err = 1'b0;
         m_frame = 1'b0;
         if (m_cur == m_last) m_run++;
         else m_run = 1;
         m_last = m_cur;
         if (m_run == SC && $countones(~m_cur[11:8]) == 1) begin
            m_idx = 0;
            for (int k = 0; k < ND; k++) if (!m_cur[8+k]) m_idx = k;
            m_val = glyph_value(m_cur[6:0]);
            m_dp[m_idx] = ~m_cur[7];
            if (m_val >= 0) begin
               m_digits[m_idx*4 +: 4] = m_val[3:0];
               m_valid[m_idx] = 1'b1;
            end else begin
               m_valid[m_idx] = 1'b0;
               m_err = 1'b1;
            end
            m_seen[m_idx] = 1'b1;
            if (&m_seen) begin
               m_frame = 1'b1;
               m_seen = '0;
            end
         end
      end
   end

   // every-cycle comparison against the model, plus pulse counting
   always @(negedge clk) begin
      n_cmp++;
      if ({digits, dp, digit_valid, pattern_err, frame_done} !==
          {m_digits, m_dp, m_valid, m_err, m_frame}) begin
         n_bad++;
         $display("FAIL model t=%0t: got dig=%h dp=%b v=%b err=%b fd=%b, required dig=%h dp=%b v=%b err=%b fd=%b",
                  $time, digits, dp, digit_valid, pattern_err, frame_done,
                  m_digits, m_dp, m_valid, m_err, m_frame);
      end
      if (frame_done) frame_cnt++;
      if (pattern_err) err_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] scan_seg [4] = '{8'hF9, 8'hA4, 8'h88, 8'h8E};
   logic [3:0] one4;
   int f0, e0;

   initial begin
      rst = 1'b1; seg_n = 8'hFF; an_n = 4'hF;
      @(negedge clk);
      // reset with a random bus
      for (int k = 0; k < 3; k++) begin
         seg_n = 8'($urandom); an_n = 4'($urandom);
         tick(1);
      end
      check("reset_digits", 32'(digits), 32'h0);
      check("reset_flags", {27'd0, dp == 4'h0, digit_valid == 4'h0, pattern_err, frame_done, 1'b0}, 32'h18);
      an_n = 4'hF; seg_n = 8'hFF;
      rst = 1'b0;
      tick(3);

      // single capture, 18 clocks pin-to-output
      an_n = 4'b1110; seg_n = 8'h30;
      tick(17);
      check("cap_early_valid", 32'(digit_valid[0]), 32'h0);
      tick(1);
      check("cap_digit0", 32'(digits[3:0]), 32'h3);
      check("cap_valid0", 32'(digit_valid[0]), 32'h1);
      check("cap_dp0", 32'(dp[0]), 32'h1);
      tick(2);

      // glitch restarts the settle window
      rst = 1'b1; an_n = 4'hF; seg_n = 8'hFF;
      tick(1);
      rst = 1'b0;
      an_n = 4'b1110; seg_n = 8'h30;
      tick(10);
      seg_n = 8'hFF;
      tick(1);
      seg_n = 8'h30;
      tick(17);
      check("glitch_hold_digit", 32'(digits[3:0]), 32'h0);
      check("glitch_hold_valid", 32'(digit_valid[0]), 32'h0);
      tick(1);
      check("glitch_cap_digit", 32'(digits[3:0]), 32'h3);

      // invalid glyph with dp lit on digit 1
      e0 = err_cnt;
      an_n = 4'b1101; seg_n = 8'h7F;
      tick(20);
      check("bad_err_pulses", 32'(err_cnt - e0), 32'h1);
      check("bad_valid1", 32'(digit_valid[1]), 32'h0);
      check("bad_dp1", 32'(dp[1]), 32'h1);
      check("bad_digit1", 32'(digits[7:4]), 32'h0);

      // anode faults, then a full scan
      rst = 1'b1; an_n = 4'hF; seg_n = 8'hFF;
      tick(1);
      rst = 1'b0;
      f0 = frame_cnt; e0 = err_cnt;
      an_n = 4'b1100; seg_n = 8'hF9;
      tick(40);
      an_n = 4'b1111;
      tick(40);
      check("fault_frames", 32'(frame_cnt - f0), 32'h0);
      check("fault_errs", 32'(err_cnt - e0), 32'h0);
      check("fault_valid", 32'(digit_valid), 32'h0);
      for (int k = 0; k < 4; k++) begin
         one4 = 4'b0001 << k;
         an_n = ~one4; seg_n = scan_seg[k];
         tick(20);
      end
      check("scan_digits", 32'(digits), 32'hFA21);
      check("scan_frames", 32'(frame_cnt - f0), 32'h1);
      check("scan_valid", 32'(digit_valid), 32'hF);
      check("scan_dp", 32'(dp), 32'h0);

      // reset while the settle counter is at 8
      an_n = 4'b1011; seg_n = 8'hB0;
      tick(11);
      rst = 1'b1;
      tick(1);
      check("midrst_digits", 32'(digits), 32'h0);
      check("midrst_valid", 32'(digit_valid), 32'h0);
      rst = 1'b0;
      tick(17);
      check("midrst_early", 32'(digit_valid[2]), 32'h0);
      tick(1);
      check("midrst_valid2", 32'(digit_valid[2]), 32'h1);
      check("midrst_digit2", 32'(digits[11:8]), 32'h3);
      check("midrst_dp2", 32'(dp[2]), 32'h0);
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
